gand16_rr_sched: RTL and testbench

//  Time-shares one 16-bit bitwise AND datapath (gand16) among N_REQ requesters.

---
 rtl/gand16_rr_sched_pkg.sv | 12 +
 rtl/gand16.sv | 10 +
 rtl/gand16_rr_sched.sv | 115 +++++++++++
 tb/tb_gand16_rr_sched.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gand16_rr_sched_pkg.sv
// Shared definitions for the gand16 round-robin scheduler: FSM encodings and datapath width.
package gand16_rr_sched_pkg;

  localparam int GAND_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } sched_state_e;

endpackage

// File: rtl/gand16.sv
// 16-bit bitwise AND datapath shared by all requesters of the scheduler.
module gand16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] y
);

  assign y = a & b;

endmodule

// File: rtl/gand16_rr_sched.sv
// Round-robin scheduler time-sharing one gand16 instance among N_REQ requesters.
// Operands are registered on grant; the result returns on a valid/ready channel.
module gand16_rr_sched
  import gand16_rr_sched_pkg::*;
#(
  parameter  int N_REQ = 4,
  parameter  int W     = GAND_W,
  localparam int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
)(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  output logic [N_REQ-1:0]   req_ready,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [W-1:0]       rsp_y,
  output logic [IDW-1:0]     rsp_id,
  output logic               busy,
  output logic [15:0]        op_count
);

  sched_state_e   state_q, state_d;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] id_r;
  logic [W-1:0]   a_r, b_r, y_w;
  logic [IDW-1:0] win_idx;
  logic           win_found;

  // First valid index at or after ptr, wrapping modulo N_REQ.
  function automatic void rr_pick(input  logic [N_REQ-1:0] v,
                                  input  logic [IDW-1:0]   p,
                                  output logic             found,
                                  output logic [IDW-1:0]   idx);
    int j;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      j = (int'(p) + k) % N_REQ;
      if (!found && v[j]) begin
        found = 1'b1;
        idx   = IDW'(j);
      end
    end
  endfunction

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    rr_pick(req_valid, ptr, win_found, win_idx);
  end

  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && win_found) req_ready[win_idx] = 1'b1;
  end

  assign busy = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_found) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  gand16 u_gand16 (
    .a (a_r),
    .b (b_r),
    .y (y_w)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      id_r      <= '0;
      a_r       <= '0;
      b_r       <= '0;
      rsp_valid <= 1'b0;
      rsp_y     <= '0;
      rsp_id    <= '0;
      op_count  <= '0;
    end else begin
      case (state_q)
        IDLE: if (win_found) begin
          a_r  <= req_a[win_idx*W +: W];
          b_r  <= req_b[win_idx*W +: W];
          id_r <= win_idx;
          // Explicit wrap keeps ptr in range when N_REQ is not a power of two.
          ptr  <= (int'(win_idx) == N_REQ-1) ? '0 : win_idx + 1'b1;
        end
        EXEC: begin
          rsp_y     <= y_w;
          rsp_id    <= id_r;
          rsp_valid <= 1'b1;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          op_count  <= op_count + 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gand16_rr_sched.sv
// Directed bench for gand16_rr_sched with N_REQ=4.
module tb_gand16_rr_sched;

  localparam int N = 4;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_a = '0;
  logic [N*W-1:0] req_b = '0;
  logic [N-1:0]   req_ready;
  logic           rsp_valid;
  logic           rsp_ready = 1'b1;
  logic [W-1:0]   rsp_y;
  logic [1:0]     rsp_id;
  logic           busy;
  logic [15:0]    op_count;

  int n_vec = 0;
  int n_err = 0;

  // Per-requester operands and hand-computed a & b.
  logic [W-1:0] ta [N] = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
  logic [W-1:0] tb [N] = '{16'h0F0F, 16'hF0F0, 16'hFF00, 16'h00FF};
  logic [W-1:0] ty [N] = '{16'h0204, 16'h5070, 16'h9A00, 16'h00F0};

  gand16_rr_sched #(.N_REQ(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_y     (rsp_y),
    .rsp_id    (rsp_id),
    .busy      (busy),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_table();
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = ta[i];
      req_b[i*W +: W] = tb[i];
    end
  endtask

  task automatic apply_reset();
    #2 rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    tick();
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({rsp_valid, rsp_y, rsp_id, busy, op_count, req_ready} !== '0) begin
      n_err++;
      $display("FAIL reset_async: got v=%b y=%h id=%0d busy=%b cnt=%0d rdy=%b, want all 0",
               rsp_valid, rsp_y, rsp_id, busy, op_count, req_ready);
    end
    tick();
    rst_n = 1'b1;
    tick();
    n_vec++;
    if (busy !== 1'b0 || req_ready !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_idle: busy=%b rdy=%b, want 0/0000", busy, req_ready);
    end
  endtask

  task automatic test_single();
    req_a[2*W +: W] = 16'hF0F0;
    req_b[2*W +: W] = 16'h0FFF;
    req_valid = 4'b0100;
    rsp_ready = 1'b1;
    #1;
    n_vec++;
    if (req_ready !== 4'b0100) begin
      n_err++;
      $display("FAIL single_grant: req_ready=%b want 0100", req_ready);
    end
    tick();
    req_valid = '0;
    n_vec++;
    if (busy !== 1'b1 || rsp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL single_exec: busy=%b rsp_valid=%b want 1/0", busy, rsp_valid);
    end
    tick();
    n_vec++;
    if (rsp_valid !== 1'b1 || rsp_y !== 16'h00F0 || rsp_id !== 2'd2) begin
      n_err++;
      $display("FAIL single_rsp: v=%b y=%h id=%0d want 1/00f0/2", rsp_valid, rsp_y, rsp_id);
    end
    tick();
    n_vec++;
    if (rsp_valid !== 1'b0 || op_count !== 16'd1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL single_done: v=%b cnt=%0d busy=%b want 0/1/0", rsp_valid, op_count, busy);
    end
  endtask

  // Runs grants in the given order with requests held; rsp_ready=1 throughout.
  task automatic run_grants(input string name, input logic [N-1:0] vmask,
                            input int ord[$], input logic [15:0] cnt_end);
    load_table();
    rsp_ready = 1'b1;
    req_valid = vmask;
    for (int k = 0; k < ord.size(); k++) begin
      #1;
      n_vec++;
      if (req_ready !== 4'(1 << ord[k])) begin
        n_err++;
        $display("FAIL %s_grant%0d: req_ready=%b want %b", name, k, req_ready, 4'(1 << ord[k]));
      end
      tick();
      if (k == ord.size() - 1) req_valid = '0;
      tick();
      n_vec++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'(ord[k]) || rsp_y !== ty[ord[k]]) begin
        n_err++;
        $display("FAIL %s_rsp%0d: v=%b id=%0d y=%h want 1/%0d/%h",
                 name, k, rsp_valid, rsp_id, rsp_y, ord[k], ty[ord[k]]);
      end
      tick();
    end
    n_vec++;
    if (op_count !== cnt_end) begin
      n_err++;
      $display("FAIL %s_count: op_count=%0d want %0d", name, op_count, cnt_end);
    end
  endtask

  task automatic test_round_robin();
    run_grants("rr", 4'b1111, '{0, 1, 2, 3, 0}, 16'd5);
  endtask

  task automatic test_skip_idle();
    // ptr is 1 after the round-robin sequence.
    run_grants("skip", 4'b1001, '{3, 0}, 16'd7);
  endtask

  task automatic test_backpressure();
    load_table();
    req_valid = 4'b0001;
    rsp_ready = 1'b0;
    tick();
    req_valid = '0;
    tick();
    req_valid = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      n_vec++;
      if (rsp_valid !== 1'b1 || rsp_y !== 16'h0204 || rsp_id !== 2'd0 || req_ready !== 4'b0000) begin
        n_err++;
        $display("FAIL bp_hold%0d: v=%b y=%h id=%0d rdy=%b want 1/0204/0/0000",
                 k, rsp_valid, rsp_y, rsp_id, req_ready);
      end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    n_vec++;
    if (rsp_valid !== 1'b0 || op_count !== 16'd8 || req_ready !== 4'b0010) begin
      n_err++;
      $display("FAIL bp_done: v=%b cnt=%0d rdy=%b want 0/8/0010", rsp_valid, op_count, req_ready);
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_reset_midop();
    apply_reset();
    load_table();
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL midop_reset: busy=%b v=%b want 0/0", busy, rsp_valid);
    end
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_vec++;
      if (rsp_valid !== 1'b0 || op_count !== 16'd0) begin
        n_err++;
        $display("FAIL midop_norsp%0d: v=%b cnt=%0d want 0/0", k, rsp_valid, op_count);
      end
    end
    // ptr back at 0: requester 1 wins over 3.
    req_valid = 4'b1010;
    #1;
    n_vec++;
    if (req_ready !== 4'b0010) begin
      n_err++;
      $display("FAIL midop_ptr: req_ready=%b want 0010", req_ready);
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_wrap();
    force dut.op_count = 16'hFFFF;
    #1 release dut.op_count;
    #1;
    n_vec++;
    if (op_count !== 16'hFFFF) begin
      n_err++;
      $display("FAIL wrap_preload: op_count=%h want ffff", op_count);
    end
    load_table();
    rsp_ready = 1'b1;
    req_valid = 4'b1000;
    tick();
    req_valid = '0;
    tick();
    n_vec++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_y !== 16'h00F0) begin
      n_err++;
      $display("FAIL wrap_rsp: v=%b id=%0d y=%h want 1/3/00f0", rsp_valid, rsp_id, rsp_y);
    end
    tick();
    n_vec++;
    if (op_count !== 16'h0000) begin
      n_err++;
      $display("FAIL wrap_count: op_count=%h want 0000", op_count);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    apply_reset();
    test_round_robin();
    test_skip_idle();
    test_backpressure();
    test_reset_midop();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
